// File: rtl/frog_position_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frog_position_ctrl
// Purpose  : Keeps the frog's row/column on the LED grid from one-cycle
//            direction pulses, clamped at the grid edges. Runs the
//            PLAY / WIN / DEAD hold sequence with respawn, and counts goals
//            in a saturating score counter. Row 0 is the start row and
//            row ROWS-1 is the goal row.
// Ports    : clock, reset (sync, active-high)
//            up/down/left/right  one-cycle move pulses
//            hit                 car collision at the frog's cell (level)
//            frog_row/frog_col   registered position
//            win                 one-cycle pulse on the first WIN cycle
//            dead                high in every DEAD cycle
//            busy                high whenever not in PLAY
//            score               goals reached, saturating
// Config   : define FROG_MOVE_COOLDOWN_EN to drop move pulses for COOLDOWN
//            cycles after every accepted move.
// Revision : 1.0  initial release
// ============================================================================
module frog_position_ctrl #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int START_COL   = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 4,
    parameter int COOLDOWN    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    up,
    input  logic                    down,
    input  logic                    left,
    input  logic                    right,
    input  logic                    hit,
    output logic [$clog2(ROWS)-1:0] frog_row,
    output logic [$clog2(COLS)-1:0] frog_col,
    output logic                    win,
    output logic                    dead,
    output logic                    busy,
    output logic [SCORE_W-1:0]      score
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [ROW_W-1:0]   ROW_PRE_GOAL = ROW_W'(ROWS - 2);
    localparam logic [COL_W-1:0]   COL_LAST     = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]   COL_START    = COL_W'(START_COL);
    localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                win_q, win_d;
    logic                move_ok;
    logic                move_taken;

`ifdef FROG_MOVE_COOLDOWN_EN
    localparam int CD_W = $clog2(COOLDOWN + 1);
    logic [CD_W-1:0] cd_q, cd_d;
`else
    // Without the lockout the move-taken flag and COOLDOWN have no consumer.
    logic unused_cfg;
    assign unused_cfg = move_taken ^ (COOLDOWN > 0);
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        score_d    = score_q;
        hold_d     = hold_q;
        win_d      = 1'b0;
        move_ok    = 1'b1;
        move_taken = 1'b0;
`ifdef FROG_MOVE_COOLDOWN_EN
        move_ok = (cd_q == '0);
        cd_d    = (cd_q != '0) ? cd_q - 1'b1 : cd_q;
`endif

        case (state_q)
            ST_PLAY: begin
                hold_d = '0;
                if (hit) begin
                    state_d = ST_DEAD;
                end else if (move_ok) begin
                    // Only the highest-priority pulse is looked at; a clamped
                    // one does not fall through to a lower-priority pulse.
                    if (up) begin
                        row_d      = row_q + 1'b1;
                        move_taken = 1'b1;
                        if (row_q == ROW_PRE_GOAL) begin
                            state_d = ST_WIN;
                            win_d   = 1'b1;
                            if (score_q != SCORE_MAX) begin
                                score_d = score_q + 1'b1;
                            end
                        end
                    end else if (down) begin
                        if (row_q != '0) begin
                            row_d      = row_q - 1'b1;
                            move_taken = 1'b1;
                        end
                    end else if (left) begin
                        if (col_q != '0) begin
                            col_d      = col_q - 1'b1;
                            move_taken = 1'b1;
                        end
                    end else if (right) begin
                        if (col_q != COL_LAST) begin
                            col_d      = col_q + 1'b1;
                            move_taken = 1'b1;
                        end
                    end
                end
            end
            ST_WIN, ST_DEAD: begin
                // Inputs are ignored here; the counter alone ends the hold.
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_PLAY;
                    row_d   = '0;
                    col_d   = COL_START;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`ifdef FROG_MOVE_COOLDOWN_EN
                cd_d = '0;
`endif
            end
            default: begin
                state_d = ST_PLAY;
                hold_d  = '0;
            end
        endcase

`ifdef FROG_MOVE_COOLDOWN_EN
        if (move_taken) begin
            cd_d = CD_W'(COOLDOWN);
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_PLAY;
            row_q   <= '0;
            col_q   <= COL_START;
            score_q <= '0;
            hold_q  <= '0;
            win_q   <= 1'b0;
`ifdef FROG_MOVE_COOLDOWN_EN
            cd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            score_q <= score_d;
            hold_q  <= hold_d;
            win_q   <= win_d;
`ifdef FROG_MOVE_COOLDOWN_EN
            cd_q    <= cd_d;
`endif
        end
    end

    assign frog_row = row_q;
    assign frog_col = col_q;
    assign score    = score_q;
    assign win      = win_q;
    assign dead     = (state_q == ST_DEAD);
    assign busy     = (state_q != ST_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_frog_position_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frog_position_ctrl
// Purpose  : Self-checking bench for frog_position_ctrl. Each driven cycle
//            feeds a behavioural game model whose predicted outputs are queued;
//            a monitor pops one prediction per clock and compares it with the
//            DUT. Directed game scenarios are followed by random play.
// Revision : 1.0  initial release
// ============================================================================
module tb_frog_position_ctrl;

    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int START_COL = 3;
    localparam int HOLD      = 4;
    localparam int SW        = 4;
    localparam int CD        = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hit = 1'b0;
    logic [2:0] frog_row, frog_col;
    logic       win, dead, busy;
    logic [3:0] score;

    frog_position_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .START_COL(START_COL),
        .HOLD_CYCLES(HOLD), .SCORE_W(SW), .COOLDOWN(CD)
    ) dut (
        .clock(clock), .reset(reset),
        .up(up), .down(down), .left(left), .right(right), .hit(hit),
        .frog_row(frog_row), .frog_col(frog_col),
        .win(win), .dead(dead), .busy(busy), .score(score)
    );

    always #5 clock = ~clock;

    typedef struct {
        int row;
        int col;
        bit win;
        bit dead;
        bit busy;
        int score;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Game model: mode 0 = playing, 1 = celebrating a goal, 2 = squashed.
    int m_row, m_col, m_mode, m_left, m_score, m_cyc, m_last_move;
    bit m_win;

    function automatic void model_reset();
        m_row = 0; m_col = START_COL; m_mode = 0; m_left = 0;
        m_score = 0; m_win = 0; m_last_move = -1000;
    endfunction

    function automatic void model_step(bit rs, bit u, bit d, bit l, bit r, bit h);
        bit allowed;
        bit moved;
        m_cyc++;
        if (rs) begin
            model_reset();
            return;
        end
        m_win = 0;
        if (m_mode != 0) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 0; m_row = 0; m_col = START_COL; m_last_move = -1000;
            end
            return;
        end
        if (h) begin
            m_mode = 2; m_left = HOLD;
            return;
        end
        allowed = 1;
`ifdef FROG_MOVE_COOLDOWN_EN
        allowed = (m_cyc - m_last_move) > CD;
`endif
        moved = 0;
        if (allowed) begin
            if (u) begin
                m_row++; moved = 1;
                if (m_row == ROWS - 1) begin
                    m_mode = 1; m_left = HOLD; m_win = 1;
                    m_score = (m_score < (1 << SW) - 1) ? m_score + 1 : m_score;
                end
            end else if (d) begin
                if (m_row > 0) begin m_row--; moved = 1; end
            end else if (l) begin
                if (m_col > 0) begin m_col--; moved = 1; end
            end else if (r) begin
                if (m_col < COLS - 1) begin m_col++; moved = 1; end
            end
        end
        if (moved) m_last_move = m_cyc;
    endfunction

    task automatic drive(input bit rs, input bit u, input bit d,
                         input bit l, input bit r, input bit h);
        exp_t e;
        @(negedge clock);
        reset = rs; up = u; down = d; left = l; right = r; hit = h;
        model_step(rs, u, d, l, r, h);
        e.row = m_row; e.col = m_col; e.win = m_win;
        e.dead = (m_mode == 2); e.busy = (m_mode != 0); e.score = m_score;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one prediction per clock edge, sampled just after the edge.
    exp_t got;
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            checks++;
            if (frog_row != got.row[2:0] || frog_col != got.col[2:0] ||
                win != got.win || dead != got.dead || busy != got.busy ||
                score != got.score[3:0]) begin
                errors++;
                $display("FAIL cycle t=%0t: got row=%0d col=%0d win=%0d dead=%0d busy=%0d score=%0d, expected row=%0d col=%0d win=%0d dead=%0d busy=%0d score=%0d",
                         $time, frog_row, frog_col, win, dead, busy, score,
                         got.row, got.col, got.win, got.dead, got.busy, got.score);
            end
        end
    end

    initial begin
        m_cyc = 0;
        model_reset();

        // Reset and a first up move.
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        idle(3);

        // Walk left into the edge, then push down at row 0.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            idle(2);
        end
        drive(0, 0, 1, 0, 0, 0);
        idle(2);

        // Coincident pulses: up beats left; clamped down swallows right.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        idle(2);
        drive(0, 1, 0, 1, 0, 0);
        idle(2);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        idle(2);

        // Sixteen goals saturate the score.
        for (int g = 0; g < 16; g++) begin
            for (int k = 0; k < ROWS - 1; k++) begin
                drive(0, 1, 0, 0, 0, 0);
                idle(2);
            end
            idle(HOLD + 1);
        end

        // Hit with up at row 2, inputs during DEAD, then reset mid-DEAD.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0); idle(2);
        drive(0, 1, 0, 0, 0, 0); idle(2);
        drive(0, 1, 0, 0, 0, 1);
        drive(0, 1, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 1, 0);
        idle(HOLD);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        idle(2);

        // Back-to-back up pulses (lockout pattern when enabled).
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        idle(2);

        // Random play.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 3);
        end
        idle(1);

        // Let the monitor drain every prediction within a bounded window.
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
